// File: rtl/decorder3to8_en_pkg.sv
// Shared widths and polarity helpers for the registered 3-to-8 decoder.
package decorder3to8_en_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 2**SEL_W;

  // Value every line settles to when the decoder is idle or in reset.
  function automatic logic [OUT_W-1:0] disabled_val(input bit active_low);
    return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

endpackage

// File: rtl/decorder3to8_en_if.sv
// Select/enable in, decoded lines out. The master drives the select side.
interface decorder3to8_en_if;
  import decorder3to8_en_pkg::*;

  logic [SEL_W-1:0] A;
  logic             EN;
  logic [OUT_W-1:0] Y;

  modport master (output A, output EN, input Y);
  modport slave  (input A, input EN, output Y);

endinterface

// File: rtl/decoder3to8_comb.sv
// Pure combinational one-hot decode; zero-hot when disabled.
module decoder3to8_comb
  import decorder3to8_en_pkg::*;
(
  input  logic [SEL_W-1:0] A,
  input  logic             EN,
  output logic [OUT_W-1:0] onehot
);

  // One compare per output line keeps each line independent of the others.
  for (genvar i = 0; i < OUT_W; i++) begin : g_line
    assign onehot[i] = EN && (A == SEL_W'(i));
  end

endmodule

// File: rtl/decorder3to8_en.sv
// Registered 3-to-8 decoder with enable and selectable output polarity.
module decorder3to8_en
  import decorder3to8_en_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  decorder3to8_en_if.slave  bus
);

  localparam logic [OUT_W-1:0] Y_OFF = disabled_val(ACTIVE_LOW);

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] y_nxt;
  logic [OUT_W-1:0] y_act;

  decoder3to8_comb u_comb (
    .A      (bus.A),
    .EN     (bus.EN),
    .onehot (onehot)
  );

  assign y_nxt = ACTIVE_LOW ? ~onehot : onehot;

  // Output register; reset parks the lines at the idle value.
  always_ff @(posedge clk) begin
    if (rst) bus.Y <= Y_OFF;
    else     bus.Y <= y_nxt;
  end

  // Active-high view of Y so the check is polarity independent.
  assign y_act = ACTIVE_LOW ? ~bus.Y : bus.Y;

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(y_act))
    else $error("decoder output has more than one active line: %h", bus.Y);

endmodule

// File: tb/tb_decorder3to8_en.sv
// Directed bench for both polarities of the registered decoder.
module tb_decorder3to8_en;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decorder3to8_en_if bus_a ();
  decorder3to8_en_if bus_b ();

  decorder3to8_en #(.ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  decorder3to8_en #(.ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.EN = 1'b1; bus_a.A = 3'd3;
    bus_b.EN = 1'b1; bus_b.A = 3'd3;
    exp_a = 8'h00;
    exp_b = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus_a.Y !== exp_a) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, bus_a.Y, exp_a);
      end
      n_checks++;
      if (bus_b.Y !== exp_b) begin
        n_fail++;
        $display("FAIL reset_hold_al[%0d]: got %h expected %h", i, bus_b.Y, exp_b);
      end
    end
    rst_a = 1'b0;
    exp_a = 8'h08;
    tick();
    n_checks++;
    if (bus_a.Y !== exp_a) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", bus_a.Y, exp_a);
    end
  endtask

  task automatic test_disabled();
    logic [2:0] sel [2] = '{3'd1, 3'd4};
    logic [7:0] exp_y;
    exp_y = 8'h00;
    bus_a.EN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_a.A = sel[i];
      tick();
      n_checks++;
      if (bus_a.Y !== exp_y) begin
        n_fail++;
        $display("FAIL disabled[A=%0d]: got %h expected %h", sel[i], bus_a.Y, exp_y);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    bus_a.EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_a.A = 3'(i);
      tick();
      n_checks++;
      if (bus_a.Y !== exp_tbl[i]) begin
        n_fail++;
        $display("FAIL sweep[A=%0d]: got %h expected %h", i, bus_a.Y, exp_tbl[i]);
      end
      n_checks++;
      if ($countones(bus_a.Y) != 1) begin
        n_fail++;
        $display("FAIL sweep_onehot[A=%0d]: got %0d active lines expected 1", i, $countones(bus_a.Y));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] sel [3] = '{3'd6, 3'd4, 3'd7};
    logic       en  [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] exp_y [3] = '{8'h40, 8'h00, 8'h80};
    for (int i = 0; i < 3; i++) begin
      bus_a.A  = sel[i];
      bus_a.EN = en[i];
      tick();
      n_checks++;
      if (bus_a.Y !== exp_y[i]) begin
        n_fail++;
        $display("FAIL en_toggle[%0d]: got %h expected %h", i, bus_a.Y, exp_y[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [2:0] sel [6] = '{3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    logic       rs  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_y [6] = '{8'h08, 8'h10, 8'h00, 8'h20, 8'h40, 8'h80};
    bus_a.EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_a.A = sel[i];
      rst_a   = rs[i];
      tick();
      n_checks++;
      if (bus_a.Y !== exp_y[i]) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got %h expected %h", i, bus_a.Y, exp_y[i]);
      end
    end
    rst_a = 1'b0;
  endtask

  task automatic test_active_low();
    logic       rs  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       en  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] sel [6] = '{3'd2, 3'd2, 3'd2, 3'd7, 3'd7, 3'd0};
    logic [7:0] exp_y [6] = '{8'hFF, 8'hFB, 8'hFF, 8'h7F, 8'hFF, 8'hFE};
    for (int i = 0; i < 6; i++) begin
      rst_b    = rs[i];
      bus_b.EN = en[i];
      bus_b.A  = sel[i];
      tick();
      n_checks++;
      if (bus_b.Y !== exp_y[i]) begin
        n_fail++;
        $display("FAIL active_low[%0d]: got %h expected %h", i, bus_b.Y, exp_y[i]);
      end
    end
    rst_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_sweep();
    test_back_to_back();
    test_midstream_reset();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
